// File: rtl/mux_4to1.sv
// Single-bit 4-to-1 mux: combinational out plus registered out_q/sel_q.
// Optional select-change pulse sel_chg enabled by `define MUX4TO1_SEL_CHG_EN.
module mux_4to1 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic       s1,
  input  logic       s0,
  output logic       out,
  output logic       out_q,
  output logic [1:0] sel_q,
  output logic       sel_chg
);

  localparam int unsigned SEL_W = 2;

  logic [SEL_W-1:0] sel;

  assign sel = {s1, s0};

  // Unknown select falls through to default so X propagates in 4-state sims.
  always_comb begin
    out = 1'bx;
    case (sel)
      2'b00:   out = in0;
      2'b01:   out = in1;
      2'b10:   out = in2;
      2'b11:   out = in3;
      default: out = 1'bx;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
      sel_q <= SEL_W'(0);
    end else begin
      out_q <= out;
      sel_q <= sel;
    end
  end

`ifdef MUX4TO1_SEL_CHG_EN
  // Compares incoming select against the last captured one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_chg <= 1'b0;
    end else begin
      sel_chg <= (sel != sel_q);
    end
  end
`else
  assign sel_chg = 1'b0;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Directed self-checking bench for mux_4to1; follows MUX4TO1_SEL_CHG_EN if defined.
module tb_mux_4to1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in0, in1, in2, in3, s1, s0;
  logic       out, out_q, sel_chg;
  logic [1:0] sel_q;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference register state, advanced in clock_edge
  logic       m_out_q;
  logic [1:0] m_sel_q;
  logic       m_chg;

  mux_4to1 dut (
    .clk(clk), .rst_n(rst_n),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .s1(s1), .s0(s0),
    .out(out), .out_q(out_q), .sel_q(sel_q), .sel_chg(sel_chg)
  );

  always #5 clk = ~clk;

  function automatic logic ref_out(input logic [3:0] d, input logic [1:0] s);
    logic r;
    case (s)
      2'b00:   r = d[0];
      2'b01:   r = d[1];
      2'b10:   r = d[2];
      default: r = d[3];
    endcase
    return r;
  endfunction

  task automatic drive(input logic [3:0] d, input logic [1:0] s);
    {in3, in2, in1, in0} = d;
    {s1, s0} = s;
  endtask

  // Advances one rising edge and updates the reference registers; returns at edge+1.
  task automatic clock_edge();
    logic       n_out_q;
    logic [1:0] n_sel_q;
    logic       n_chg;
    n_out_q = ref_out({in3, in2, in1, in0}, {s1, s0});
    n_sel_q = {s1, s0};
`ifdef MUX4TO1_SEL_CHG_EN
    n_chg = ({s1, s0} != m_sel_q);
`else
    n_chg = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (rst_n) begin
      m_out_q = n_out_q;
      m_sel_q = n_sel_q;
      m_chg   = n_chg;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_out_q = 1'b0; m_sel_q = 2'b00; m_chg = 1'b0;
    drive(4'b0001, 2'b00);
    #3;
    n_checks++; if (out_q !== 1'b0) begin n_fail++; $display("FAIL reset_out_q got=%b exp=0", out_q); end
    n_checks++; if (sel_q !== 2'b00) begin n_fail++; $display("FAIL reset_sel_q got=%b exp=00", sel_q); end
    n_checks++; if (sel_chg !== 1'b0) begin n_fail++; $display("FAIL reset_sel_chg got=%b exp=0", sel_chg); end
    n_checks++; if (out !== 1'b1) begin n_fail++; $display("FAIL reset_out_comb got=%b exp=1", out); end
    clock_edge();
    n_checks++; if (out_q !== 1'b0) begin n_fail++; $display("FAIL reset_hold_out_q got=%b exp=0", out_q); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_case1();
    drive(4'b0001, 2'b00);
    #1;
    n_checks++; if (out !== 1'b1) begin n_fail++; $display("FAIL case1_out got=%b exp=1", out); end
    clock_edge();
    n_checks++; if (out_q !== 1'b1) begin n_fail++; $display("FAIL case1_out_q got=%b exp=1", out_q); end
    n_checks++; if (sel_chg !== 1'b0) begin n_fail++; $display("FAIL case1_first_sel_chg got=%b exp=0", sel_chg); end
  endtask

  task automatic test_case2();
    logic exp_chg;
`ifdef MUX4TO1_SEL_CHG_EN
    exp_chg = 1'b1;
`else
    exp_chg = 1'b0;
`endif
    drive(4'b0010, 2'b01);
    #1;
    n_checks++; if (out !== 1'b1) begin n_fail++; $display("FAIL case2_out got=%b exp=1", out); end
    clock_edge();
    n_checks++; if (sel_q !== 2'b01) begin n_fail++; $display("FAIL case2_sel_q got=%b exp=01", sel_q); end
    n_checks++; if (sel_chg !== exp_chg) begin n_fail++; $display("FAIL case2_sel_chg got=%b exp=%b", sel_chg, exp_chg); end
    clock_edge();
    n_checks++; if (sel_chg !== 1'b0) begin n_fail++; $display("FAIL case2_sel_chg_drop got=%b exp=0", sel_chg); end
  endtask

  task automatic test_case3();
    drive(4'b0100, 2'b10);
    #1;
    n_checks++; if (out !== 1'b1) begin n_fail++; $display("FAIL case3_out got=%b exp=1", out); end
    clock_edge();
    n_checks++; if (out_q !== 1'b1) begin n_fail++; $display("FAIL case3_out_q got=%b exp=1", out_q); end
    in2 = 1'b0;
    #1;
    n_checks++; if (out !== 1'b0) begin n_fail++; $display("FAIL case3_out_toggle got=%b exp=0", out); end
    clock_edge();
    n_checks++; if (out_q !== 1'b0) begin n_fail++; $display("FAIL case3_out_q_toggle got=%b exp=0", out_q); end
  endtask

  task automatic test_case4();
    drive(4'b1000, 2'b11);
    #1;
    n_checks++; if (out !== 1'b1) begin n_fail++; $display("FAIL case4_out got=%b exp=1", out); end
    in0 = 1'b1; in1 = 1'b1; in2 = 1'b1;
    #1;
    n_checks++; if (out !== 1'b1) begin n_fail++; $display("FAIL case4_others_high got=%b exp=1", out); end
    in0 = 1'b0; in1 = 1'b0; in2 = 1'b0;
    #1;
    n_checks++; if (out !== 1'b1) begin n_fail++; $display("FAIL case4_others_low got=%b exp=1", out); end
    clock_edge();
    n_checks++; if (out_q !== 1'b1) begin n_fail++; $display("FAIL case4_out_q got=%b exp=1", out_q); end
    n_checks++; if (sel_q !== 2'b11) begin n_fail++; $display("FAIL case4_sel_q got=%b exp=11", sel_q); end
  endtask

  // Reset asserted between edges while out_q=1 and sel_q=11
  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_q !== 1'b0) begin n_fail++; $display("FAIL async_out_q got=%b exp=0", out_q); end
    n_checks++; if (sel_q !== 2'b00) begin n_fail++; $display("FAIL async_sel_q got=%b exp=00", sel_q); end
    n_checks++; if (sel_chg !== 1'b0) begin n_fail++; $display("FAIL async_sel_chg got=%b exp=0", sel_chg); end
    n_checks++; if (out !== 1'b1) begin n_fail++; $display("FAIL async_out_comb got=%b exp=1", out); end
    in3 = 1'b0;
    #1;
    n_checks++; if (out !== 1'b0) begin n_fail++; $display("FAIL async_out_track got=%b exp=0", out); end
    m_out_q = 1'b0; m_sel_q = 2'b00; m_chg = 1'b0;
    #1 rst_n = 1'b1;
    clock_edge();
    n_checks++; if (sel_q !== 2'b11) begin n_fail++; $display("FAIL async_first_capture got=%b exp=11", sel_q); end
  endtask

  // Data and select change together; select changes on consecutive edges
  task automatic test_back_to_back();
    drive(4'b0110, 2'b00);
    clock_edge();
    n_checks++; if (out_q !== 1'b0) begin n_fail++; $display("FAIL b2b_base_out_q got=%b exp=0", out_q); end
    drive(4'b1001, 2'b11);
    clock_edge();
    n_checks++; if (out_q !== 1'b1) begin n_fail++; $display("FAIL b2b_same_edge_out_q got=%b exp=1", out_q); end
    n_checks++; if (sel_chg !== m_chg) begin n_fail++; $display("FAIL b2b_chg1 got=%b exp=%b", sel_chg, m_chg); end
    drive(4'b1001, 2'b10);
    clock_edge();
    n_checks++; if (out_q !== 1'b0) begin n_fail++; $display("FAIL b2b_next_out_q got=%b exp=0", out_q); end
    n_checks++; if (sel_q !== 2'b10) begin n_fail++; $display("FAIL b2b_next_sel_q got=%b exp=10", sel_q); end
    n_checks++; if (sel_chg !== m_chg) begin n_fail++; $display("FAIL b2b_chg2 got=%b exp=%b", sel_chg, m_chg); end
  endtask

  task automatic test_exhaustive();
    logic [5:0] v;
    logic       exp;
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      drive(v[3:0], v[5:4]);
      exp = v[3'(v[5:4])];
      #1;
      n_checks++; if (out !== exp) begin n_fail++; $display("FAIL exh_out vec=%0d got=%b exp=%b", i, out, exp); end
      clock_edge();
      n_checks++; if (out_q !== m_out_q) begin n_fail++; $display("FAIL exh_out_q vec=%0d got=%b exp=%b", i, out_q, m_out_q); end
      n_checks++; if (sel_q !== m_sel_q) begin n_fail++; $display("FAIL exh_sel_q vec=%0d got=%b exp=%b", i, sel_q, m_sel_q); end
      n_checks++; if (sel_chg !== m_chg) begin n_fail++; $display("FAIL exh_sel_chg vec=%0d got=%b exp=%b", i, sel_chg, m_chg); end
    end
  endtask

  initial begin
    test_reset();
    test_case1();
    test_case2();
    test_case3();
    test_case4();
    test_async_reset();
    test_back_to_back();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_4to1.md
# mux_4to1

Single-bit 4-to-1 multiplexer with a combinational data path and a registered output stage. Selects one of four scalar inputs using a 2-bit select split into `s1` (MSB) and `s0` (LSB). Used as a leaf data-steering cell; the combinational `out` serves glue logic, and `out_q` / `sel_q` serve clocked consumers.

## Interface

- No parameters; all data ports are 1 bit.
- One clock; reset is asynchronous and active-low.
- `clk` input 1: rising-edge clock for all registers.
- `rst_n` input 1: asynchronous active-low reset.
- `in0` input 1: data input, selected when {s1,s0}=00.
- `in1` input 1: data input, selected when {s1,s0}=01.
- `in2` input 1: data input, selected when {s1,s0}=10.
- `in3` input 1: data input, selected when {s1,s0}=11.
- `s1` input 1: select MSB.
- `s0` input 1: select LSB.
- `out` output 1: combinational selected input.
- `out_q` output 1: `out` registered on `clk`.
- `sel_q` output 2: {s1,s0} registered on `clk`.
- `sel_chg` output 1: one-cycle pulse when the registered select changes.

## Operation

- `out` = in[{s1,s0}]: 00→in0, 01→in1, 10→in2, 11→in3.
- `out` is purely combinational and independent of `clk` and `rst_n`. It is valid whenever inputs are stable, including during reset.
- Any X/Z on `s1` or `s0` drives `out` to X in simulation. No X-masking.
- Each rising `clk`: `out_q` ← `out`, `sel_q` ← {s1,s0}.
- `sel_chg` is registered. Each rising `clk` it loads ({s1,s0} != `sel_q`), so it is high for the cycle after a select change is captured.
- The first clock after reset release compares against `sel_q`=00. A select of 00 at that point gives `sel_chg`=0.
- No state machine. No internal counters.

## Timing

- `out`: zero-cycle combinational latency from any input.
- `out_q`, `sel_q`, `sel_chg`: one-cycle latency, updated on rising `clk`.
- Reset values while `rst_n`=0: `out_q`=0, `sel_q`=2'b00, `sel_chg`=0. `out` keeps following inputs.
- Reset assert mid-operation clears the registers immediately, without waiting for `clk`.
- Reset deassert is synchronised externally. The first capture occurs on the first rising `clk` with `rst_n`=1.
- A data change and a select change in the same cycle are both captured by the same edge. `out_q` reflects the new select applied to the new data.

## Configuration

- Macro `MUX4TO1_SEL_CHG_EN`.
- Defined: `sel_chg` register and comparator are present, behaving as described above.
- Undefined: `sel_chg` is tied to constant 0 and no comparator is synthesised. All other behaviour is identical.

## Test plan

- Case 1: in=1,0,0,0 (in0..in3), {s1,s0}=00, wait 10 ns → `out`=1. Next `clk` → `out_q`=1.
- Case 2: in=0,1,0,0, sel=01 → `out`=1. After edge, `sel_q`=01 and `sel_chg`=1 (macro defined) for one cycle, then 0.
- Case 3: in=0,0,1,0, sel=10 → `out`=1; with the same sel, toggle in2 to 0 → `out`=0, and `out_q`=0 after the next edge.
- Case 4: in=0,0,0,1, sel=11 → `out`=1. Non-selected inputs toggling leave `out` at 1.
- Reset: assert `rst_n`=0 between clock edges with `out_q`=1 → `out_q`=0, `sel_q`=00, `sel_chg`=0 immediately, while `out` still tracks inputs.
- Exhaustive: all 64 combinations of in0..in3, s1, s0 → `out` matches the select table. Repeat with the macro undefined → `sel_chg` stays 0 throughout.
